// File: rtl/err_metric_if.sv
// err_metric_if: sample-pair stream from the adder harness into the error-metric engine.
interface err_metric_if #(
   parameter int W = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [W:0]   exact_res;
   logic [W:0]   approx_res;
   modport master(output in_valid, exact_res, approx_res, input in_ready);
   modport slave(input in_valid, exact_res, approx_res, output in_ready);
endinterface

// File: rtl/err_metric_accum.sv
// err_metric_accum: streaming error-count / error-distance accumulator for approximate-adder characterisation.
module err_metric_accum #(
   parameter int W     = 16,
   parameter int CNT_W = 32,
   parameter int ACC_W = 48
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   err_metric_if.slave      s,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count,
   output logic [ACC_W-1:0] sum_ed,
   output logic [W:0]       max_ed,
   output logic [CNT_W-1:0] nz_count,
   output logic             acc_sat
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t           state;
   logic [CNT_W-1:0] target;
   logic [CNT_W-1:0] accepted;
   logic             drain_last;
   logic             s1_vld;
   logic             s1_mis;
   logic             s1_nz;
   logic [W:0]       s1_ed;
   logic             xfer;
   logic [W+1:0]     diff;
   logic [W:0]       ed_c;
   logic [ACC_W:0]   sum_next;
   always_comb begin
      xfer     = s.in_valid & s.in_ready;
      diff     = {1'b0, s.exact_res} - {1'b0, s.approx_res};
      ed_c     = diff[W+1] ? (W+1)'(-diff) : diff[W:0];
      sum_next = {1'b0, sum_ed} + {{(ACC_W-W){1'b0}}, s1_ed};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         target     <= '0;
         accepted   <= '0;
         drain_last <= 1'b0;
         s1_vld     <= 1'b0;
         s1_mis     <= 1'b0;
         s1_nz      <= 1'b0;
         s1_ed      <= '0;
         s.in_ready <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err_count  <= '0;
         sum_ed     <= '0;
         max_ed     <= '0;
         nz_count   <= '0;
         acc_sat    <= 1'b0;
      end else begin
         s1_vld <= xfer;
         s1_ed  <= ed_c;
         s1_mis <= s.exact_res != s.approx_res;
         s1_nz  <= |s.exact_res;
         if (s1_vld) begin
            err_count <= err_count + CNT_W'(s1_mis);
            nz_count  <= nz_count + CNT_W'(s1_nz);
            max_ed    <= (s1_ed > max_ed) ? s1_ed : max_ed;
            sum_ed    <= sum_next[ACC_W] ? '1 : sum_next[ACC_W-1:0];
            acc_sat   <= acc_sat | sum_next[ACC_W];
         end
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  target    <= num_samples;
                  accepted  <= '0;
                  err_count <= '0;
                  sum_ed    <= '0;
                  max_ed    <= '0;
                  nz_count  <= '0;
                  acc_sat   <= 1'b0;
                  done      <= num_samples == '0;
                  busy      <= num_samples != '0;
                  s.in_ready <= num_samples != '0;
                  state     <= (num_samples == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (xfer) begin
                  accepted <= accepted + 1'b1;
                  if (accepted == target - 1'b1) begin
                     s.in_ready <= 1'b0;
                     drain_last <= 1'b0;
                     state      <= DRAIN;
                  end
               end
            end
            default: begin
               // two drain cycles let the last sample clear both pipeline stages
               drain_last <= 1'b1;
               if (drain_last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_err_metric_accum.sv
// tb_err_metric_accum: directed runs with a done-triggered scoreboard of expected result sets.
module tb_err_metric_accum;
   localparam int W = 16, CNT_W = 32, ACC_W = 18;
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_samples = '0;
   logic             busy, done, acc_sat;
   logic [CNT_W-1:0] err_count, nz_count;
   logic [ACC_W-1:0] sum_ed;
   logic [W:0]       max_ed;
   err_metric_if #(.W(W)) bus();
   err_metric_accum #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .s(bus),
      .busy(busy), .done(done), .err_count(err_count), .sum_ed(sum_ed),
      .max_ed(max_ed), .nz_count(nz_count), .acc_sat(acc_sat)
   );
   typedef struct packed {
      logic [CNT_W-1:0] ec;
      logic [ACC_W-1:0] se;
      logic [W:0]       me;
      logic [CNT_W-1:0] nz;
      logic             sat;
   } exp_t;
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic done_q = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask
   task automatic push(input logic [CNT_W-1:0] ec, input logic [ACC_W-1:0] se,
                       input logic [W:0] me, input logic [CNT_W-1:0] nz, input logic sat);
      sb.push_back('{ec: ec, se: se, me: me, nz: nz, sat: sat});
   endtask
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (done && !done_q) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'(sb.size()), 1);
         end else begin
            e = sb.pop_front();
            chk("err_count", err_count, e.ec);
            chk("sum_ed", sum_ed, e.se);
            chk("max_ed", max_ed, e.me);
            chk("nz_count", nz_count, e.nz);
            chk("acc_sat", acc_sat, e.sat);
         end
      end
      done_q = done;
   end
   task automatic start_run(input logic [CNT_W-1:0] n);
      @(negedge clk);
      start = 1'b1;
      num_samples = n;
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic send(input logic [W:0] e, input logic [W:0] a);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.exact_res = e;
      bus.approx_res = a;
      while (!bus.in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) chk("send_timeout", bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask
   task automatic wait_done();
      int t = 0;
      while (!done && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("done_timeout", done, 1);
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_in_ready"}, bus.in_ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err_count"}, err_count, 0);
      chk({tag, "_sum_ed"}, sum_ed, 0);
      chk({tag, "_max_ed"}, max_ed, 0);
      chk({tag, "_nz_count"}, nz_count, 0);
      chk({tag, "_acc_sat"}, acc_sat, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [4:0] pat;
      bus.in_valid = 1'b0;
      bus.exact_res = '0;
      bus.approx_res = '0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      // zero-sample run straight from IDLE
      push(0, 0, 0, 0, 0);
      start_run(0);
      chk("zero_done", done, 1);
      chk("zero_in_ready", bus.in_ready, 0);
      @(negedge clk);
      chk("zero_in_ready_hold", bus.in_ready, 0);
      // abort a run after three erroneous transfers
      start_run(5);
      send(17'd100, 17'd0);
      send(17'd100, 17'd0);
      send(17'd100, 17'd0);
      @(negedge clk);
      chk("pre_abort_err_count", err_count, 3);
      rst_n = 1'b0;
      #1;
      chk_zero("abort");
      @(negedge clk);
      rst_n = 1'b1;
      push(2, 4, 2, 2, 0);
      start_run(2);
      send(17'd3, 17'd1);
      send(17'd1, 17'd3);
      wait_done();
      // exact-match run with done latency check
      push(0, 0, 0, 3, 0);
      start_run(4);
      send(17'h00010, 17'h00010);
      send(17'h1FFFF, 17'h1FFFF);
      send(17'h00000, 17'h00000);
      send(17'h00005, 17'h00005);
      chk("exact_busy_drain", busy, 1);
      chk("exact_done_c1", done, 0);
      @(negedge clk);
      chk("exact_done_c2", done, 0);
      @(negedge clk);
      chk("exact_done_c3", done, 1);
      // mixed errors
      push(2, 264, 256, 2, 0);
      start_run(3);
      send(17'h10000, 17'h0FF00);
      send(17'h00050, 17'h00058);
      send(17'h00000, 17'h00000);
      wait_done();
      // stalls on in_valid, then an extra pair that must be refused
      push(3, 3, 1, 3, 0);
      start_run(3);
      pat = 5'b11001;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = pat[i];
         bus.exact_res = 17'(i + 2);
         bus.approx_res = 17'(i + 1);
         chk("stall_in_ready", bus.in_ready, 1);
         @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.exact_res = 17'd200;
      bus.approx_res = 17'd0;
      chk("stall_ready_drop", bus.in_ready, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_done();
      // saturation of an 18-bit accumulator
      push(4, 18'h3FFFF, 17'h1FFFF, 4, 1);
      start_run(4);
      for (int i = 0; i < 4; i++) send(17'h1FFFF, 17'h00000);
      wait_done();
      // start pulsed mid-run must be ignored
      push(2, 7, 4, 2, 0);
      start_run(3);
      send(17'd10, 17'd7);
      start_run(1);
      chk("restart_busy", busy, 1);
      chk("restart_in_ready", bus.in_ready, 1);
      send(17'd20, 17'd20);
      send(17'd0, 17'd4);
      wait_done();
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/err_metric_accum.md
Name: err_metric_accum

Overview:
- Synthesizable, streaming error-metric engine for approximate-adder characterisation.
- Sits beside a DUT adder (e.g. a HOERAA instance) and a reference exact adder.
- Consumes pairs of (exact, approximate) results over a valid/ready handshake for a programmed sample count.
- Accumulates error count, total error distance, maximum error distance and non-zero-exact count; software or a host derives ER, MED, NMED and MRED from these.

Parameters:
- W, 16, adder operand width; compared results are W+1 bits (sum plus carry-out).
- CNT_W, 32, width of sample and error counters.
- ACC_W, 48, width of the error-distance accumulator; must be >= W+1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run; honoured only in IDLE or DONE.
- num_samples  in  CNT_W  samples for the run; sampled on an accepted start.
- in_valid  in  1  sample pair present.
- in_ready  out  1  engine accepts a sample this cycle.
- exact_res  in  W+1  exact {carry, sum}.
- approx_res  in  W+1  approximate {carry, sum}.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; results stable.
- err_count  out  CNT_W  samples with approx_res != exact_res.
- sum_ed  out  ACC_W  sum of |exact_res - approx_res|.
- max_ed  out  W+1  largest single error distance.
- nz_count  out  CNT_W  samples with exact_res != 0 (MRED denominator).
- acc_sat  out  1  sum_ed saturated during the run (sticky until next start).

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0, busy=0, done=0, acc_sat=0; all counters and accumulators 0.
- States:
  - IDLE: wait for start.
  - RUN: accepting samples.
  - DRAIN: pipeline empties.
  - DONE: results held.
- IDLE/DONE -> start: latch num_samples, clear all result outputs and acc_sat.
  - If num_samples==0: go to DONE on the next cycle with all results 0.
  - Otherwise: go to RUN.
- start while busy is ignored; a run is not restarted.
- RUN:
  - in_ready=1 while accepted < num_samples.
  - Transfer occurs when in_valid && in_ready.
  - When the last transfer occurs, in_ready drops the following cycle and state moves to DRAIN.
- Pipeline:
  - Stage 1 registers ed = |exact_res - approx_res|, computed at W+2 bits; ed fits in W+1 bits.
  - Stage 1 also registers the mismatch bit and the nonzero bit.
  - Stage 2 updates err_count, sum_ed, max_ed and nz_count.
  - A sample's contribution is visible in the outputs 2 cycles after its transfer.
- DRAIN lasts exactly 2 cycles. done rises on the 3rd cycle after the last transfer, and the outputs then include all samples.
- in_valid low stalls without penalty; no bubbles are counted.
- Saturation: if sum_ed + ed exceeds 2^ACC_W-1, sum_ed holds at all-ones and acc_sat=1. Counters do not wrap, since at most num_samples <= 2^CNT_W-1 transfers occur.
- max_ed updates only when ed is strictly greater than max_ed.
- DONE: outputs held; done stays high until the next accepted start, which clears done on the following cycle.
- rst_n asserted mid-run: immediate abort to reset values; no partial results are retained.
- Inputs are ignored outside RUN; a transfer requires in_ready.

Test Plan:
- Reset mid-run: assert rst_n=0 after 3 transfers -> in_ready=0, busy=0, done=0, all outputs 0 immediately; a subsequent start with num_samples=2 behaves as a fresh run.
- Exact-match run: W=16, num_samples=4, pairs exact=approx=0x00010, 0x1FFFF, 0x00000, 0x00005 -> done 3 cycles after the 4th transfer; err_count=0, sum_ed=0, max_ed=0, nz_count=3.
- Mixed errors: num_samples=3:
  - (exact 0x10000, approx 0x0FF00) -> ed 0x100.
  - (0x00050, 0x00058) -> ed 8.
  - (0x00000, 0x00000) -> ed 0.
  - Result: err_count=2, sum_ed=264, max_ed=256, nz_count=2, acc_sat=0.
- Backpressure/stall: in_valid toggles 1,0,0,1,1 with num_samples=3 -> exactly 3 transfers counted; in_ready falls the cycle after the 3rd transfer; a 4th valid pair is not accepted.
- Saturation: ACC_W=18, W=16, 4 samples each with ed=0x1FFFF -> sum_ed=0x3FFFF, acc_sat=1, err_count=4, max_ed=0x1FFFF.
- Control corners:
  - start with num_samples=0 -> done=1 on the next cycle, results 0, in_ready never high.
  - start pulsed during RUN -> ignored; counts unchanged.
